// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
//  - default PC / instruction widths
//  - 4-bit opcode constants (NOP=0 ... BRNZ=F)
//  - sequencer state encoding
//  - registered control-decoder bundle
package instr_sequencer_pkg;

    localparam int PC_W_DEFAULT    = 12;
    localparam int INSTR_W_DEFAULT = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_CMP   = 4'h5,
        OP_XOR   = 4'h6,
        OP_MOV   = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_JMP   = 4'hA,
        OP_JZ    = 4'hB,
        OP_JN    = 4'hC,
        OP_JP    = 4'hD,
        OP_BRZ   = 4'hE,
        OP_BRNZ  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // Decoder outputs captured at the end of DECODE.
    typedef struct packed {
        logic branch;
        logic jump;
        logic compare;
        logic mem_read;
        logic mem_write;
        logic reg_load;
    } ctl_t;

endpackage

// File: rtl/instr_sequencer_pc_next.sv
// pc_next: combinational next-PC / condition unit.
// Ports:
//  pc       in   PC_W  current PC
//  opcode   in   4     opcode of the instruction in flight (selects the condition)
//  field    in   12    target / offset field instr[11:0]
//  branch   in   1     registered decoder branch
//  jump     in   1     registered decoder jump
//  compare  in   1     registered decoder compare (with jump: conditional jump)
//  flag_z   in   1     latched zero flag
//  flag_n   in   1     latched negative flag
//  next_pc  out  PC_W  PC of the next instruction (mod 2^PC_W)
module pc_next
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc,
    input  logic [3:0]      opcode,
    input  logic [11:0]     field,
    input  logic            branch,
    input  logic            jump,
    input  logic            compare,
    input  logic            flag_z,
    input  logic            flag_n,
    output logic [PC_W-1:0] next_pc
);

    logic taken;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        taken   = 1'b0;
        next_pc = pc + PC_W'(1);
        if (jump) begin
            if (!compare) begin
                taken = 1'b1;
            end else begin
                case (opcode)
                    OP_JZ:   taken = flag_z;
                    OP_JN:   taken = flag_n;
                    OP_JP:   taken = !flag_z && !flag_n;
                    default: taken = 1'b0;
                endcase
            end
            // Absolute target: zero-extended (or truncated) to PC_W.
            if (taken) next_pc = PC_W'(field);
        end else if (branch) begin
            case (opcode)
                OP_BRZ:  taken = flag_z;
                OP_BRNZ: taken = !flag_z;
                default: taken = 1'b0;
            endcase
            // Relative offset: sign-extended, sum wraps mod 2^PC_W.
            if (taken) next_pc = pc + PC_W'($signed(field));
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/issue sequencer.
// Fetches from instruction memory, presents the opcode to the control decoder,
// sequences EXEC / MEM / WB, and owns the PC and the {Z,N} flags.
// Ports:
//  clk, rstN                       clock, async active-low reset
//  halt                            hold in FETCH without requesting
//  imemReq/imemAddr/imemAck/imemData  instruction fetch handshake
//  instr, opcode                   latched instruction and its opcode slice
//  branch..regLoad                 control decoder outputs (registered in DECODE)
//  aluZero, aluNeg                 ALU flags, sampled in EXEC for compare
//  execEn                          one-cycle execute strobe
//  dmemReq/dmemWe/dmemAck          data-memory handshake
//  regWe                           one-cycle register write strobe
//  pc                              current PC
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter int              INSTR_W  = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               halt,
    output logic               imemReq,
    output logic [PC_W-1:0]    imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    input  logic               branch,
    input  logic               jump,
    input  logic               compare,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic               regLoad,
    input  logic               aluZero,
    input  logic               aluNeg,
    output logic               execEn,
    output logic               dmemReq,
    output logic               dmemWe,
    input  logic               dmemAck,
    output logic               regWe,
    output logic [PC_W-1:0]    pc
);

    state_e          state, state_next;
    ctl_t            ctl;
    logic            flag_z, flag_n;
    logic [PC_W-1:0] pc_nxt;
    logic            imem_req_d, exec_en_d, dmem_req_d, dmem_we_d, reg_we_d;
    logic            fetch_done;

    assign imemAddr = pc;
    assign opcode   = instr[INSTR_W-1 -: 4];

    // An ack only counts while our own registered request is up, so acks
    // during/just after reset or outside FETCH are ignored. A request that is
    // already up when halt rises may still complete on that cycle.
    assign fetch_done = (state == ST_FETCH) && imemReq && imemAck;

    // ctl, pc, instr and flags are all stable from EXEC through WB, so the
    // next PC can be taken straight from this unit when WB commits it.
    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc),
        .opcode  (opcode),
        .field   (instr[11:0]),
        .branch  (ctl.branch),
        .jump    (ctl.jump),
        .compare (ctl.compare),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .next_pc (pc_nxt)
    );

    // Next state plus the next value of every registered strobe; strobes are
    // registered so that no ack reaches a request combinationally.
    always_comb begin
        state_next = state;
        imem_req_d = 1'b0;
        exec_en_d  = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        reg_we_d   = 1'b0;
        case (state)
            ST_FETCH: begin
                if (fetch_done) state_next = ST_DECODE;
                else            imem_req_d = !halt;
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
                exec_en_d  = 1'b1;
            end
            ST_EXEC: begin
                if (ctl.mem_read || ctl.mem_write) begin
                    state_next = ST_MEM;
                    dmem_req_d = 1'b1;
                    dmem_we_d  = ctl.mem_write;
                end else begin
                    state_next = ST_WB;
                    reg_we_d   = ctl.reg_load;
                end
            end
            ST_MEM: begin
                if (dmemAck) begin
                    state_next = ST_WB;
                    reg_we_d   = ctl.reg_load;
                end else begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = ctl.mem_write;
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                imem_req_d = !halt;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= ST_FETCH;
            imemReq <= 1'b0;
            execEn  <= 1'b0;
            dmemReq <= 1'b0;
            dmemWe  <= 1'b0;
            regWe   <= 1'b0;
        end else begin
            state   <= state_next;
            imemReq <= imem_req_d;
            execEn  <= exec_en_d;
            dmemReq <= dmem_req_d;
            dmemWe  <= dmem_we_d;
            regWe   <= reg_we_d;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc     <= RESET_PC;
            instr  <= '0;
            ctl    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            case (state)
                ST_FETCH:  if (fetch_done) instr <= imemData;
                ST_DECODE: ctl <= {branch, jump, compare, memRead, memWrite, regLoad};
                ST_EXEC: begin
                    // Only a plain compare (op 5) updates the flags.
                    if (ctl.compare && !ctl.jump) begin
                        flag_z <= aluZero;
                        flag_n <= aluNeg;
                    end
                end
                ST_WB:     pc <= pc_nxt;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer (RESET_PC = 0x010).
// An ISA-level model (opcode semantics + instruction latency) predicts the
// strobes, PC and instruction every cycle; directed fetch-address and
// strobe-count literals pin the model.
module tb_instr_sequencer;

    localparam int          PC_W    = 12;
    localparam int          INSTR_W = 16;
    localparam logic [11:0] RST_PC  = 12'h010;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         halt = 1'b0;
    logic         imemReq, imemAck, execEn, dmemReq, dmemWe, regWe;
    logic [11:0]  imemAddr, pc;
    logic [15:0]  imemData, instr;
    logic [3:0]   opcode;
    logic         branch, jump, compare, memRead, memWrite, regLoad;
    logic         aluZero, aluNeg;
    logic         dmemAck = 1'b0;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rstN(rstN), .halt(halt),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
        .instr(instr), .opcode(opcode),
        .branch(branch), .jump(jump), .compare(compare),
        .memRead(memRead), .memWrite(memWrite), .regLoad(regLoad),
        .aluZero(aluZero), .aluNeg(aluNeg), .execEn(execEn),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAck(dmemAck),
        .regWe(regWe), .pc(pc)
    );

    // ---------------- environment ----------------
    logic [15:0] imem [0:4095];
    bit          alu_z_tab [0:4095];
    bit          alu_n_tab [0:4095];
    assign imemData = imem[imemAddr];
    assign aluZero  = alu_z_tab[pc];
    assign aluNeg   = alu_n_tab[pc];

    int   imem_lat = 0, imem_cnt = 0, dmem_lat = 3, dmem_cnt = 0;
    logic imem_tie = 1'b1, imem_ack_r = 1'b0;
    assign imemAck = imem_tie | imem_ack_r;

    // Memory responders: ack after *_lat wait cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (imemReq) begin
            if (imem_cnt >= imem_lat) imem_ack_r = 1'b1;
            else begin imem_ack_r = 1'b0; imem_cnt++; end
        end else begin
            imem_ack_r = 1'b0; imem_cnt = 0;
        end
        if (dmemReq) begin
            if (dmem_cnt >= dmem_lat) dmemAck = 1'b1;
            else begin dmemAck = 1'b0; dmem_cnt++; end
        end else begin
            dmemAck = 1'b0; dmem_cnt = 0;
        end
    end

    // Control decoder stand-in.
    always_comb begin
        {branch, jump, compare, memRead, memWrite, regLoad} = 6'b0;
        case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7: regLoad = 1'b1;
            4'h5:                   compare = 1'b1;
            4'h8:                   begin memRead = 1'b1; regLoad = 1'b1; end
            4'h9:                   memWrite = 1'b1;
            4'hA:                   jump = 1'b1;
            4'hB, 4'hC, 4'hD:       begin jump = 1'b1; compare = 1'b1; end
            4'hE, 4'hF:             branch = 1'b1;
            default:                ;
        endcase
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ISA-level model state.
    logic [11:0] m_pc = RST_PC, e_next;
    logic [15:0] m_instr = '0;
    logic        m_z = 1'b0, m_n = 1'b0;
    bit          e_load, e_store, e_rwe, e_mem, busy = 0, halt_prev = 0, rst_prev = 1;
    int          mem_cyc = 0, c = 0;

    // c counts cycles after the fetch ack: 1 DECODE, 2 EXEC, 3..2+mem_cyc MEM,
    // 3+mem_cyc WB; afterwards the new PC is visible.
    always @(negedge clk) begin
        if (!rstN) begin
            check("rst_strobes", {imemReq, execEn, dmemReq, dmemWe, regWe}, 0);
            check("rst_pc", pc, RST_PC);
            check("rst_instr", instr, 0);
            m_pc = RST_PC; m_z = 1'b0; m_n = 1'b0; busy = 0;
        end else if (busy) begin
            c++;
            check("strobes{ireq,exec,dreq,rwe}", {imemReq, execEn, dmemReq, regWe},
                  {1'b0, c == 2, e_mem && c >= 3 && c <= 2 + mem_cyc, e_rwe && c == 3 + mem_cyc});
            if (dmemReq) check("dmem_we", dmemWe, e_store);
            check("busy_pc", pc, m_pc);
            check("instr", instr, m_instr);
            check("opcode", opcode, m_instr[15:12]);
            if (c == 3 + mem_cyc) begin busy = 0; m_pc = e_next; end
        end else begin
            check("idle_strobes", {execEn, dmemReq, regWe}, 0);
            check("idle_req", imemReq, !(halt_prev || rst_prev));
            check("idle_pc", pc, m_pc);
            if (imemReq) check("fetch_addr", imemAddr, m_pc);
            if (imemReq && imemAck) begin
                logic [11:0] t;
                m_instr = imemData;
                t = imemData[11:0];
                e_next = m_pc + 12'd1;
                e_load = 0; e_store = 0; e_rwe = 0;
                case (imemData[15:12])
                    4'h5: begin m_z = alu_z_tab[m_pc]; m_n = alu_n_tab[m_pc]; end
                    4'h8: begin e_load = 1; e_rwe = 1; end
                    4'h9: e_store = 1;
                    4'hA: e_next = t;
                    4'hB: if (m_z) e_next = t;
                    4'hC: if (m_n) e_next = t;
                    4'hD: if (!m_z && !m_n) e_next = t;
                    4'hE: if (m_z) e_next = m_pc + t;
                    4'hF: if (!m_z) e_next = m_pc + t;
                    4'h0: ;
                    default: e_rwe = 1;
                endcase
                e_mem   = e_load || e_store;
                mem_cyc = e_mem ? dmem_lat + 1 : 0;
                busy = 1; c = 0;
            end
        end
        halt_prev = halt;
        rst_prev  = !rstN;
    end

    // Wait (bounded) for the next accepted fetch and check its address.
    task automatic wait_fetch(input logic [11:0] exp, output int at);
        bit got = 0;
        at = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (rstN && imemReq && imemAck) begin got = 1; at = cyc; end
        end
        if (got) check($sformatf("fetch@%03h", exp), imemAddr, exp);
        else     check($sformatf("fetch_timeout@%03h", exp), 0, 1);
    endtask

    task automatic observe(input int n, output int dreq, output int dwe, output int rwe);
        dreq = 0; dwe = 0; rwe = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dreq += int'(dmemReq); dwe += int'(dmemWe); rwe += int'(regWe);
        end
    endtask

    logic [11:0] trace [22] = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h0FF, 12'h100,
                                12'h020, 12'h021, 12'h022, 12'h023, 12'h005, 12'h003,
                                12'hFFF, 12'h000, 12'h001, 12'h040, 12'h041, 12'h050,
                                12'h051, 12'h052, 12'h053, 12'h056};

    initial begin
        int at, prev_at, dreq, dwe, rwe;
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
        imem[12'h013] = 16'hA0FF;  imem[12'h0FF] = 16'h5000;  imem[12'h100] = 16'hB020;
        imem[12'h020] = 16'h5000;  imem[12'h021] = 16'hB030;  imem[12'h022] = 16'h5000;
        imem[12'h023] = 16'hA005;  imem[12'h005] = 16'hEFFE;  imem[12'h003] = 16'hAFFF;
        imem[12'hFFF] = 16'hF010;  imem[12'h000] = 16'h5000;  imem[12'h001] = 16'hC040;
        imem[12'h040] = 16'h5000;  imem[12'h041] = 16'hD050;  imem[12'h050] = 16'h8000;
        imem[12'h051] = 16'h9000;  imem[12'h052] = 16'h1000;  imem[12'h053] = 16'hF003;
        imem[12'h056] = 16'h8000;
        alu_z_tab[12'h0FF] = 1'b1;
        alu_z_tab[12'h022] = 1'b1;
        alu_n_tab[12'h000] = 1'b1;

        // Reset with imemAck tied high; the early acks must be ignored.
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        prev_at = 0;
        foreach (trace[i]) begin
            wait_fetch(trace[i], at);
            if (i == 1 || i == 2) check("nop_fetch_spacing", at - prev_at, 4);
            prev_at = at;
            if (trace[i] == 12'h013) begin
                observe(3, dreq, dwe, rwe);
                check("jmp_no_regwe_dreq", {dreq[7:0], rwe[7:0]}, 0);
            end
            if (trace[i] == 12'h050) begin
                observe(7, dreq, dwe, rwe);
                check("load_dreq_cycles", dreq, 4);
                check("load_dwe_cycles", dwe, 0);
                check("load_regwe_pulses", rwe, 1);
            end
            if (trace[i] == 12'h051) begin
                observe(7, dreq, dwe, rwe);
                check("store_dwe_cycles", dwe, 4);
                check("store_regwe_pulses", rwe, 0);
            end
            if (trace[i] == 12'h053) dmem_lat = 50;
        end

        // Reset in the middle of a long MEM phase.
        begin
            bit seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = dmemReq;
            end
            check("mem_req_before_reset", seen, 1);
        end
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        check("async_rst_strobes", {imemReq, execEn, dmemReq, dmemWe, regWe}, 0);
        check("async_rst_pc", pc, RST_PC);
        imem_lat = 2;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        imem_tie = 1'b0;

        // Halt raised mid-instruction: that instruction finishes, then FETCH idles.
        wait_fetch(12'h010, at);
        @(posedge clk);
        #1 halt = 1'b1;
        repeat (12) @(negedge clk);
        check("halt_pc_frozen", pc, 12'h011);
        check("halt_no_req", imemReq, 0);
        @(posedge clk);
        #1 halt = 1'b0;
        wait_fetch(12'h011, at);
        wait_fetch(12'h012, at);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
